// File: rtl/lockstep_sync_barrier_if.sv
// Bus bundle for lockstep_sync_barrier: configuration port, per-core sync
// request/grant pairs and the lockstep mode / status outputs.
// slave is the barrier side, master is the side driving requests.
interface lockstep_sync_barrier_if #(
  parameter int unsigned NB_CORES = 8
);
  logic                cfg_req_i;
  logic                cfg_wen_i;
  logic [31:0]         cfg_wdata_i;
  logic                cfg_gnt_o;
  logic                cfg_rvalid_o;
  logic [31:0]         cfg_rdata_o;
  logic [NB_CORES-1:0] core_req_i;
  logic [NB_CORES-1:0] core_gnt_o;
  logic                lockstep_mode_if;
  logic                lockstep_mode_id;
  logic                busy_o;
  logic                err_o;

  modport slave (
    input  cfg_req_i, cfg_wen_i, cfg_wdata_i, core_req_i,
    output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, core_gnt_o,
           lockstep_mode_if, lockstep_mode_id, busy_o, err_o
  );

  modport master (
    output cfg_req_i, cfg_wen_i, cfg_wdata_i, core_req_i,
    input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, core_gnt_o,
           lockstep_mode_if, lockstep_mode_id, busy_o, err_o
  );
endinterface

// File: rtl/lockstep_sync_barrier.sv
// Lockstep mode-change barrier for the cluster cores.
// A config write arms a new {id,if} mode; all cores are then gathered and
// released together in one cycle, and the new mode is applied only at that
// release so no core ever runs in a mode its peers have not entered.
// Optional macro LOCKSTEP_SYNC_TIMEOUT_EN adds a gather timeout that aborts
// the barrier, releases the cores already arrived and sets a sticky error.
module lockstep_sync_barrier #(
  parameter int unsigned NB_CORES       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  lockstep_sync_barrier_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATHER  = 2'd1,
    RELEASE = 2'd2,
    ABORT   = 2'd3
  } state_e;

  state_e              state;
  logic [NB_CORES-1:0] arrived;
  logic [1:0]          pending_mode;
  logic [1:0]          active_mode;
  logic                cfg_wr;
  logic                all_in;
  logic                err;
  logic [31:0]         status;

  assign cfg_wr = bus.cfg_req_i & ~bus.cfg_wen_i;
  // Release condition includes cores arriving in this very cycle.
  assign all_in = &(arrived | bus.core_req_i);

`ifdef LOCKSTEP_SYNC_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] cnt;
  logic                 timeout_hit;
  logic                 unused_wdata;

  assign timeout_hit  = (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign unused_wdata = ^bus.cfg_wdata_i[30:2];

  // Barrier FSM with gather timeout; release wins over a coincident timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      arrived      <= '0;
      pending_mode <= 2'b00;
      active_mode  <= 2'b00;
      cnt          <= '0;
      err          <= 1'b0;
    end else begin
      if (cfg_wr && bus.cfg_wdata_i[31]) begin
        err <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (cfg_wr) begin
            pending_mode <= bus.cfg_wdata_i[1:0];
            state        <= GATHER;
          end
        end
        GATHER: begin
          arrived <= arrived | bus.core_req_i;
          if (all_in) begin
            cnt   <= '0;
            state <= RELEASE;
          end else if (timeout_hit) begin
            cnt   <= '0;
            state <= ABORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          active_mode <= pending_mode;
          arrived     <= '0;
          state       <= IDLE;
        end
        ABORT: begin
          err     <= 1'b1;
          arrived <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_cfg;

  // Without the timeout the error bit and the timeout sizing are inert.
  assign err        = 1'b0;
  assign unused_cfg = ^{bus.cfg_wdata_i[31:2], TIMEOUT_CYCLES[0], CNT_WIDTH[0]};

  // Barrier FSM: arm on write, gather indefinitely, release all together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      arrived      <= '0;
      pending_mode <= 2'b00;
      active_mode  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_wr) begin
            pending_mode <= bus.cfg_wdata_i[1:0];
            state        <= GATHER;
          end
        end
        GATHER: begin
          arrived <= arrived | bus.core_req_i;
          if (all_in) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          active_mode <= pending_mode;
          arrived     <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

  assign status = {err, 26'b0, (state != IDLE), pending_mode, active_mode};

  // Registered config response; a write returns the status before it lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.cfg_rvalid_o <= 1'b0;
      bus.cfg_rdata_o  <= 32'h0;
    end else begin
      bus.cfg_rvalid_o <= bus.cfg_req_i;
      if (bus.cfg_req_i) begin
        bus.cfg_rdata_o <= status;
      end
    end
  end

  // Grant steering: transparent when idle, held low while gathering.
  always_comb begin
    bus.core_gnt_o = '0;
    case (state)
      IDLE:    bus.core_gnt_o = bus.core_req_i;
      RELEASE: bus.core_gnt_o = '1;
`ifdef LOCKSTEP_SYNC_TIMEOUT_EN
      ABORT:   bus.core_gnt_o = arrived;
`endif
      default: bus.core_gnt_o = '0;
    endcase
  end

  assign bus.cfg_gnt_o        = 1'b1;
  assign bus.lockstep_mode_if = active_mode[0];
  assign bus.lockstep_mode_id = active_mode[1];
  assign bus.busy_o           = (state != IDLE);
  assign bus.err_o            = err;

endmodule

// File: tb/tb_lockstep_sync_barrier.sv
// Directed bench for lockstep_sync_barrier: reset state, staggered gather,
// all-ready release with ignored re-arm, idle transparency, optional
// timeout abort and reset during gather.
module tb_lockstep_sync_barrier;
  localparam int unsigned NB = 8;
  localparam int unsigned TO = 16;

  logic clk;
  logic rst_n;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  lockstep_sync_barrier_if #(.NB_CORES(NB)) bus ();

  lockstep_sync_barrier #(
    .NB_CORES       (NB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_idle();
    bus.cfg_req_i   = 1'b0;
    bus.cfg_wen_i   = 1'b1;
    bus.cfg_wdata_i = 32'h0;
  endtask

  task automatic cfg_write(input logic [31:0] d);
    bus.cfg_req_i   = 1'b1;
    bus.cfg_wen_i   = 1'b0;
    bus.cfg_wdata_i = d;
  endtask

  task automatic cfg_read();
    bus.cfg_req_i   = 1'b1;
    bus.cfg_wen_i   = 1'b1;
    bus.cfg_wdata_i = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_idle();
    bus.core_req_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy_o); else pass_cnt++;
    chk_cnt++; if (bus.core_gnt_o !== 8'h00) $display("FAIL rst_gnt got %h exp 00", bus.core_gnt_o); else pass_cnt++;
    chk_cnt++; if ({bus.lockstep_mode_id, bus.lockstep_mode_if} !== 2'b00) $display("FAIL rst_mode got %b%b exp 00", bus.lockstep_mode_id, bus.lockstep_mode_if); else pass_cnt++;
    chk_cnt++; if (bus.err_o !== 1'b0) $display("FAIL rst_err got %b exp 0", bus.err_o); else pass_cnt++;
    chk_cnt++; if (bus.cfg_rvalid_o !== 1'b0) $display("FAIL rst_rvalid got %b exp 0", bus.cfg_rvalid_o); else pass_cnt++;
    chk_cnt++; if (bus.cfg_gnt_o !== 1'b1) $display("FAIL cfg_gnt got %b exp 1", bus.cfg_gnt_o); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    cfg_read();
    tick();
    cfg_idle();
    @(negedge clk);
    chk_cnt++; if (bus.cfg_rvalid_o !== 1'b1) $display("FAIL rst_read_rvalid got %b exp 1", bus.cfg_rvalid_o); else pass_cnt++;
    chk_cnt++; if (bus.cfg_rdata_o !== 32'h0) $display("FAIL rst_read_rdata got %h exp 00000000", bus.cfg_rdata_o); else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++; if (bus.cfg_rvalid_o !== 1'b0) $display("FAIL rvalid_pulse got %b exp 0", bus.cfg_rvalid_o); else pass_cnt++;
  endtask

  task automatic test_staggered();
    tick();
    cfg_write(32'h3);
    tick();
    cfg_idle();
    for (int c = 1; c <= 15; c++) begin
      if (c > 1) tick();
      if (c % 2 == 1) bus.core_req_i[(c - 1) / 2] = 1'b1;
      @(negedge clk);
      chk_cnt++; if (bus.core_gnt_o !== 8'h00) $display("FAIL stag_gnt_c%0d got %h exp 00", c, bus.core_gnt_o); else pass_cnt++;
    end
    tick();
    @(negedge clk);
    chk_cnt++; if (bus.core_gnt_o !== 8'hFF) $display("FAIL stag_release_gnt got %h exp ff", bus.core_gnt_o); else pass_cnt++;
    chk_cnt++; if (bus.lockstep_mode_if !== 1'b0) $display("FAIL stag_mode_early got %b exp 0", bus.lockstep_mode_if); else pass_cnt++;
    tick();
    bus.core_req_i = '0;
    @(negedge clk);
    chk_cnt++; if (bus.core_gnt_o !== 8'h00) $display("FAIL stag_gnt_after got %h exp 00", bus.core_gnt_o); else pass_cnt++;
    chk_cnt++; if ({bus.lockstep_mode_id, bus.lockstep_mode_if} !== 2'b11) $display("FAIL stag_mode got %b%b exp 11", bus.lockstep_mode_id, bus.lockstep_mode_if); else pass_cnt++;
    chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL stag_busy got %b exp 0", bus.busy_o); else pass_cnt++;
    cfg_read();
    tick();
    cfg_idle();
    @(negedge clk);
    chk_cnt++; if (bus.cfg_rdata_o !== 32'h0000_000F) $display("FAIL stag_status got %h exp 0000000f", bus.cfg_rdata_o); else pass_cnt++;
  endtask

  task automatic test_all_ready();
    tick();
    cfg_write(32'h1);
    bus.core_req_i = 8'hFF;
    @(negedge clk);
    chk_cnt++; if (bus.core_gnt_o !== 8'hFF) $display("FAIL ar_idle_gnt got %h exp ff", bus.core_gnt_o); else pass_cnt++;
    tick();
    cfg_write(32'h2);
    @(negedge clk);
    chk_cnt++; if (bus.core_gnt_o !== 8'h00) $display("FAIL ar_c1_gnt got %h exp 00", bus.core_gnt_o); else pass_cnt++;
    chk_cnt++; if (bus.busy_o !== 1'b1) $display("FAIL ar_c1_busy got %b exp 1", bus.busy_o); else pass_cnt++;
    chk_cnt++; if (bus.cfg_rdata_o !== 32'h0000_000F) $display("FAIL ar_prewrite got %h exp 0000000f", bus.cfg_rdata_o); else pass_cnt++;
    tick();
    cfg_read();
    @(negedge clk);
    chk_cnt++; if (bus.core_gnt_o !== 8'hFF) $display("FAIL ar_c2_gnt got %h exp ff", bus.core_gnt_o); else pass_cnt++;
    chk_cnt++; if (bus.cfg_rdata_o !== 32'h0000_0017) $display("FAIL ar_busy_write got %h exp 00000017", bus.cfg_rdata_o); else pass_cnt++;
    tick();
    cfg_idle();
    bus.core_req_i = '0;
    @(negedge clk);
    chk_cnt++; if ({bus.lockstep_mode_id, bus.lockstep_mode_if} !== 2'b01) $display("FAIL ar_mode got %b%b exp 01", bus.lockstep_mode_id, bus.lockstep_mode_if); else pass_cnt++;
    chk_cnt++; if (bus.cfg_rdata_o !== 32'h0000_0017) $display("FAIL ar_release_status got %h exp 00000017", bus.cfg_rdata_o); else pass_cnt++;
    cfg_read();
    tick();
    cfg_idle();
    @(negedge clk);
    chk_cnt++; if (bus.cfg_rdata_o !== 32'h0000_0005) $display("FAIL ar_pending got %h exp 00000005", bus.cfg_rdata_o); else pass_cnt++;
  endtask

  task automatic test_transparent();
    tick();
    bus.core_req_i = 8'h21;
    @(negedge clk);
    chk_cnt++; if (bus.core_gnt_o !== 8'h21) $display("FAIL tr_gnt got %h exp 21", bus.core_gnt_o); else pass_cnt++;
    tick();
    bus.core_req_i = '0;
    @(negedge clk);
    chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL tr_busy got %b exp 0", bus.busy_o); else pass_cnt++;
    chk_cnt++; if (bus.core_gnt_o !== 8'h00) $display("FAIL tr_gnt_drop got %h exp 00", bus.core_gnt_o); else pass_cnt++;
  endtask

`ifdef LOCKSTEP_SYNC_TIMEOUT_EN
  task automatic test_timeout();
    tick();
    cfg_write(32'h3);
    tick();
    cfg_idle();
    bus.core_req_i = 8'h7F;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      @(negedge clk);
      chk_cnt++; if (bus.core_gnt_o !== 8'h00) $display("FAIL to_gnt_c%0d got %h exp 00", c, bus.core_gnt_o); else pass_cnt++;
    end
    tick();
    @(negedge clk);
    chk_cnt++; if (bus.core_gnt_o !== 8'h7F) $display("FAIL to_abort_gnt got %h exp 7f", bus.core_gnt_o); else pass_cnt++;
    tick();
    bus.core_req_i = '0;
    @(negedge clk);
    chk_cnt++; if (bus.err_o !== 1'b1) $display("FAIL to_err got %b exp 1", bus.err_o); else pass_cnt++;
    chk_cnt++; if ({bus.lockstep_mode_id, bus.lockstep_mode_if} !== 2'b01) $display("FAIL to_mode got %b%b exp 01", bus.lockstep_mode_id, bus.lockstep_mode_if); else pass_cnt++;
    chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL to_busy got %b exp 0", bus.busy_o); else pass_cnt++;
    cfg_read();
    tick();
    cfg_idle();
    @(negedge clk);
    chk_cnt++; if (bus.cfg_rdata_o !== 32'h8000_000D) $display("FAIL to_status got %h exp 8000000d", bus.cfg_rdata_o); else pass_cnt++;
    tick();
    cfg_write(32'h8000_0000);
    tick();
    cfg_idle();
    @(negedge clk);
    chk_cnt++; if (bus.err_o !== 1'b0) $display("FAIL to_err_clear got %b exp 0", bus.err_o); else pass_cnt++;
    bus.core_req_i = 8'hFF;
    tick();
    @(negedge clk);
    chk_cnt++; if (bus.core_gnt_o !== 8'hFF) $display("FAIL to_rearm_gnt got %h exp ff", bus.core_gnt_o); else pass_cnt++;
    tick();
    bus.core_req_i = '0;
    @(negedge clk);
    chk_cnt++; if ({bus.lockstep_mode_id, bus.lockstep_mode_if} !== 2'b00) $display("FAIL to_rearm_mode got %b%b exp 00", bus.lockstep_mode_id, bus.lockstep_mode_if); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid_gather();
    tick();
    cfg_write(32'h3);
    tick();
    cfg_idle();
    bus.core_req_i = 8'h0F;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    bus.core_req_i = '0;
    #1;
    chk_cnt++; if (bus.core_gnt_o !== 8'h00) $display("FAIL mid_rst_gnt got %h exp 00", bus.core_gnt_o); else pass_cnt++;
    chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", bus.busy_o); else pass_cnt++;
    chk_cnt++; if ({bus.lockstep_mode_id, bus.lockstep_mode_if} !== 2'b00) $display("FAIL mid_rst_mode got %b%b exp 00", bus.lockstep_mode_id, bus.lockstep_mode_if); else pass_cnt++;
    chk_cnt++; if (bus.cfg_rdata_o !== 32'h0) $display("FAIL mid_rst_rdata got %h exp 00000000", bus.cfg_rdata_o); else pass_cnt++;
    chk_cnt++; if (bus.err_o !== 1'b0) $display("FAIL mid_rst_err got %b exp 0", bus.err_o); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_cnt++; if (bus.core_gnt_o !== 8'h00) $display("FAIL mid_rst_hold_gnt%0d got %h exp 00", i, bus.core_gnt_o); else pass_cnt++;
    end
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL mid_rst_after_busy got %b exp 0", bus.busy_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_staggered();
    test_all_ready();
    test_transparent();
`ifdef LOCKSTEP_SYNC_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_gather();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
